// File: rtl/y86_pkg.sv
// y86_pkg: constants shared by the condition-code resolver and the cmov datapath.
//   C_*            Y86 jXX/cmovXX ifun encodings
//   CC_RESET       CC register value after reset ({ZF,SF,OF} = 3'b100)
//   ZF/SF/OF_BIT   bit positions of each flag inside a {ZF,SF,OF} vector
package y86_pkg;

    localparam logic [3:0] C_YES = 4'd0;
    localparam logic [3:0] C_LE  = 4'd1;
    localparam logic [3:0] C_L   = 4'd2;
    localparam logic [3:0] C_E   = 4'd3;
    localparam logic [3:0] C_NE  = 4'd4;
    localparam logic [3:0] C_GE  = 4'd5;
    localparam logic [3:0] C_G   = 4'd6;

    localparam logic [2:0] CC_RESET = 3'b100;

    localparam int ZF_BIT = 2;
    localparam int SF_BIT = 1;
    localparam int OF_BIT = 0;

endpackage

// File: rtl/cc_resolver_if.sv
// cc_resolver_if: condition query / response handshake between decode and
// the condition-code resolver.
//   q_valid, q_ifun   query from decode (held stable while q_ready is low)
//   q_ready           query accepted when q_valid & q_ready
//   r_valid           one-cycle response strobe, one cycle after acceptance
//   r_cnd, r_err      condition result / ifun out of range; zero when r_valid=0
// Modports: master = decode/fetch side, slave = resolver side.
interface cc_resolver_if;

    logic       q_valid;
    logic [3:0] q_ifun;
    logic       q_ready;
    logic       r_valid;
    logic       r_cnd;
    logic       r_err;

    modport master (
        output q_valid, q_ifun,
        input  q_ready, r_valid, r_cnd, r_err
    );

    modport slave (
        input  q_valid, q_ifun,
        output q_ready, r_valid, r_cnd, r_err
    );

endinterface

// File: rtl/cond_eval.sv
// cond_eval: purely combinational Y86 condition evaluator, shared with the
// cmov datapath.
//   ifun_i   jXX/cmovXX function code
//   flags_i  {ZF,SF,OF}
//   cnd_o    condition true
//   err_o    ifun_i above 6 (cnd_o forced low)
module cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun_i,
    input  logic [2:0] flags_i,
    output logic       cnd_o,
    output logic       err_o
);

    logic zf;
    logic lt;

    assign zf = flags_i[ZF_BIT];
    assign lt = flags_i[SF_BIT] ^ flags_i[OF_BIT];

    always_comb begin
        cnd_o = 1'b0;
        err_o = 1'b0;
        case (ifun_i)
            C_YES:   cnd_o = 1'b1;
            C_LE:    cnd_o = lt | zf;
            C_L:     cnd_o = lt;
            C_E:     cnd_o = zf;
            C_NE:    cnd_o = ~zf;
            C_GE:    cnd_o = ~lt;
            C_G:     cnd_o = ~lt & ~zf;
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/cc_resolver.sv
// cc_resolver: owns the architectural condition-code register, counts
// flag-setting OPq instructions in flight, and answers jXX/cmovXX condition
// queries once no flag update is outstanding.
//   clk, rst_n            clock, asynchronous active-low reset
//   alu_zf/sf/of, set_cc  ALU flags and their latch strobe
//   iss_valid, iss_ready  OPq issue handshake (ready while counter not full)
//   qif                   query/response handshake (slave side)
//   cc                    current {ZF,SF,OF}
//   pend                  outstanding OPq count
// Build option CC_BYPASS_EN: a query may also be accepted in the cycle the
// last outstanding flag update lands, evaluating the incoming ALU flags.
module cc_resolver
    import y86_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_zf,
    input  logic              alu_sf,
    input  logic              alu_of,
    input  logic              set_cc,
    input  logic              iss_valid,
    output logic              iss_ready,
    cc_resolver_if.slave      qif,
    output logic [2:0]        cc,
    output logic [PEND_W-1:0] pend
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [2:0]        cc_q, cc_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              r_valid_q, r_valid_d;
    logic              r_cnd_q, r_cnd_d;
    logic              r_err_q, r_err_d;

    logic [2:0] alu_flags;
    logic [2:0] eval_flags;
    logic       iss_fire;
    logic       q_fire;
    logic       cnd;
    logic       err;

    assign alu_flags = {alu_zf, alu_sf, alu_of};
    assign iss_ready = (pend_q != PEND_MAX);
    assign iss_fire  = iss_valid & iss_ready;

`ifdef CC_BYPASS_EN
    // The landing update can be forwarded only when it is the last one out.
    assign qif.q_ready = (pend_q == '0) | ((pend_q == PEND_ONE) & set_cc);
    assign eval_flags  = set_cc ? alu_flags : cc_q;
`else
    assign qif.q_ready = (pend_q == '0) & ~set_cc;
    assign eval_flags  = cc_q;
`endif

    assign q_fire = qif.q_valid & qif.q_ready;

    cond_eval u_cond_eval (
        .ifun_i  (qif.q_ifun),
        .flags_i (eval_flags),
        .cnd_o   (cnd),
        .err_o   (err)
    );

    always_comb begin
        cc_d = set_cc ? alu_flags : cc_q;

        // Issue and flag landing in the same cycle cancel out; a stray
        // set_cc with nothing pending still latches CC but leaves pend at 0.
        pend_d = pend_q;
        if (iss_fire && !set_cc) begin
            pend_d = pend_q + PEND_ONE;
        end else if (set_cc && !iss_fire && (pend_q != '0)) begin
            pend_d = pend_q - PEND_ONE;
        end

        r_valid_d = q_fire;
        r_cnd_d   = q_fire & cnd;
        r_err_d   = q_fire & err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q      <= CC_RESET;
            pend_q    <= '0;
            r_valid_q <= 1'b0;
            r_cnd_q   <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            cc_q      <= cc_d;
            pend_q    <= pend_d;
            r_valid_q <= r_valid_d;
            r_cnd_q   <= r_cnd_d;
            r_err_q   <= r_err_d;
        end
    end

    assign cc          = cc_q;
    assign pend        = pend_q;
    assign qif.r_valid = r_valid_q;
    assign qif.r_cnd   = r_cnd_q;
    assign qif.r_err   = r_err_q;

endmodule
